gf180mcu_fd_sc_mcu9t5v0__dffnsnq_preset_seq: RTL

Staggered preset sequencer for banks of negative-edge, set-capable flops (dffnsnq family). On request, it stops the bank clock and drives per-group active-low SETN lines one group at a time, which limits simultaneous set current. Each SETN pulse meets the minimum-low-width requirement; the sequencer then holds the clock off for a recovery window before re-enabling it. It sits between the power/init controller and the gated CLKN tree and SETN nets of the flop bank.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffnsnq_preset_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnsnq_preset_seq.sv
// Staggered preset sequencer for dffnsnq flop banks: stops the bank clock,
// pulses one SETN group at a time, waits out recovery, then re-enables the clock.
module gf180mcu_fd_sc_mcu9t5v0__dffnsnq_preset_seq #(
  parameter int NGRP = 4,
  parameter int PW   = 2,
  parameter int GAP  = 1,
  parameter int RCV  = 2
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            REQ,
  input  logic [NGRP-1:0] GMASK,
  output logic [NGRP-1:0] SETN_O,
  output logic            CKEN,
  output logic            BUSY,
  output logic            DONE
);

  localparam int MAXD = (PW > GAP) ? ((PW > RCV) ? PW : RCV)
                                   : ((GAP > RCV) ? GAP : RCV);
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_PULSE,
    S_GAP,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [NGRP-1:0] rmask, rmask_n;
  logic [NGRP-1:0] cur_grp, nxt_grp;
  logic [NGRP-1:0] setn_n;
  logic            cken_n, busy_n, done_n;

  // Lowest set bit of the remaining mask, now and after this cycle's update.
  assign cur_grp = rmask & (~rmask + NGRP'(1));
  assign nxt_grp = rmask_n & (~rmask_n + NGRP'(1));

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rmask  <= '0;
      SETN_O <= '1;
      CKEN   <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rmask  <= rmask_n;
      SETN_O <= setn_n;
      CKEN   <= cken_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rmask_n = rmask;
    case (state)
      S_IDLE: begin
        if (REQ) begin
          rmask_n = GMASK;
          state_n = (GMASK == '0) ? S_DONE : S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        state_n = S_PULSE;
        cnt_n   = CW'(PW);
      end
      S_PULSE: begin
        if (cnt == CW'(1)) begin
          rmask_n = rmask & ~cur_grp;
          if (rmask_n == '0) begin
            state_n = S_RECOVER;
            cnt_n   = CW'(RCV);
          end else if (GAP > 0) begin
            state_n = S_GAP;
            cnt_n   = CW'(GAP);
          end else begin
            state_n = S_PULSE;
            cnt_n   = CW'(PW);
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == CW'(1)) begin
          state_n = S_PULSE;
          cnt_n   = CW'(PW);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_RECOVER: begin
        if (cnt == CW'(1)) state_n = S_DONE;
        else               cnt_n   = cnt - CW'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops glitch-free.
  always_comb begin
    setn_n = '1;
    if (state_n == S_PULSE) setn_n = ~nxt_grp;
    cken_n = (state_n == S_IDLE) || (state_n == S_DONE);
    busy_n = !cken_n;
    done_n = (state_n == S_DONE);
  end

endmodule
